// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 instruction-fetch stage. It owns the PC, fetches over req/ready and fills IF/ID.
// Optional macro FETCH_PERF_EN adds saturating fetched/bubble counters (tied to 0 otherwise).
module fetch_unit #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [N-1:0]     i_redirect_pc,
  output logic             o_imem_req,
  output logic [N-1:0]     o_imem_addr,
  input  logic             i_imem_ready,
  input  logic [31:0]      i_imem_rdata,
  output logic             o_ifid_valid,
  output logic [N-1:0]     o_ifid_pc,
  output logic [31:0]      o_ifid_instr,
  output logic [CNT_W-1:0] o_perf_fetched,
  output logic [CNT_W-1:0] o_perf_bubbles
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [N-1:0] PC_STEP  = N'(4);
  localparam logic [N-1:0] ADDR_MSK = ~N'(3);

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_pc, w_pc_nxt;
  logic         r_req;
  logic         r_drop, w_drop_nxt;
  logic [N-1:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0]  r_skid_instr, w_skid_instr_nxt;
  logic         r_ifid_valid, w_ifid_valid_nxt;
  logic [N-1:0] r_ifid_pc, w_ifid_pc_nxt;
  logic [31:0]  r_ifid_instr, w_ifid_instr_nxt;
  logic         w_ifid_load;
  logic         w_accept;

  // Next-state and IF/ID update; priority is redirect > stall > normal (reset handled in the flops).
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_nxt       = r_drop;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_load      = 1'b0;
    w_accept         = (r_state == ST_FETCH) && i_imem_ready && !r_drop;
    if (i_redirect) begin
      w_ifid_load      = 1'b1;
      w_ifid_valid_nxt = 1'b0;
      w_ifid_instr_nxt = 32'h0;
      w_skid_pc_nxt    = '0;
      w_skid_instr_nxt = 32'h0;
      w_pc_nxt         = i_redirect_pc & ADDR_MSK;
      w_state_nxt      = ST_FETCH;
      // A request still in flight will answer later for the old PC; discard that answer.
      w_drop_nxt       = (r_state == ST_FETCH) && !i_imem_ready;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          if (i_imem_ready) begin
            w_drop_nxt = 1'b0;
          end else begin
            w_drop_nxt = r_drop;
          end
          if (w_accept) begin
            w_pc_nxt = r_pc + PC_STEP;
            if (i_stall) begin
              w_skid_pc_nxt    = r_pc;
              w_skid_instr_nxt = i_imem_rdata;
              w_state_nxt      = ST_HOLD;
            end else begin
              w_ifid_load      = 1'b1;
              w_ifid_valid_nxt = 1'b1;
              w_ifid_pc_nxt    = r_pc;
              w_ifid_instr_nxt = i_imem_rdata;
            end
          end else if (!i_stall) begin
            w_ifid_load      = 1'b1;
            w_ifid_valid_nxt = 1'b0;
            w_ifid_instr_nxt = 32'h0;
          end else begin
            w_ifid_load = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            w_ifid_load      = 1'b1;
            w_ifid_valid_nxt = 1'b1;
            w_ifid_pc_nxt    = r_skid_pc;
            w_ifid_instr_nxt = r_skid_instr;
            w_skid_pc_nxt    = '0;
            w_skid_instr_nxt = 32'h0;
            w_state_nxt      = ST_FETCH;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        default: begin
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_drop       <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req        <= (w_state_nxt == ST_FETCH);
      r_drop       <= w_drop_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      if (w_ifid_load) begin
        r_ifid_valid <= w_ifid_valid_nxt;
        r_ifid_pc    <= w_ifid_pc_nxt;
        r_ifid_instr <= w_ifid_instr_nxt;
      end else begin
        r_ifid_valid <= r_ifid_valid;
        r_ifid_pc    <= r_ifid_pc;
        r_ifid_instr <= r_ifid_instr;
      end
    end
  end

  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_pc;
  assign o_ifid_valid = r_ifid_valid;
  assign o_ifid_pc    = r_ifid_pc;
  assign o_ifid_instr = r_ifid_instr;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] r_perf_fetched;
  logic [CNT_W-1:0] r_perf_bubbles;

  // Saturating counters of IF/ID loads; held-stall cycles are not loads and are not counted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_ifid_load && w_ifid_valid_nxt && !(&r_perf_fetched)) begin
        r_perf_fetched <= r_perf_fetched + CNT_W'(1);
      end else begin
        r_perf_fetched <= r_perf_fetched;
      end
      if (w_ifid_load && !w_ifid_valid_nxt && !(&r_perf_bubbles)) begin
        r_perf_bubbles <= r_perf_bubbles + CNT_W'(1);
      end else begin
        r_perf_bubbles <= r_perf_bubbles;
      end
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_bubbles = r_perf_bubbles;
`else
  assign o_perf_fetched = '0;
  assign o_perf_bubbles = '0;
`endif

endmodule
